// File: rtl/la_capture_writer_if.sv
// -----------------------------------------------------------------------------
// la_capture_writer_if
// Write-client bus between one logic-analyzer capture writer and the memory
// arbiter (one 128-bit laN_wr_* port).
//   wr_en   : writer -> arbiter, a word is being offered
//   wr_addr : writer -> arbiter, DRAM address of wr_data
//   wr_data : writer -> arbiter, 128-bit capture word
//   wr_ack  : arbiter -> writer, current word accepted this cycle
// -----------------------------------------------------------------------------
interface la_capture_writer_if;
    logic         wr_en;
    logic [28:0]  wr_addr;
    logic [127:0] wr_data;
    logic         wr_ack;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/la_capture_writer.sv
// -----------------------------------------------------------------------------
// la_capture_writer
// Capture-side write client for one logic-analyzer channel (clk_ram_2x domain).
// Buffers a 128-bit capture stream in a small first-word-fall-through FIFO and
// writes it into a circular DRAM region through the arbiter write port.
// Supports arm, trigger and a post-trigger word count, then flushes and
// reports the address of the first post-trigger word.
//
// Ports:
//   clk_ram_2x     : sole clock
//   rst_n          : asynchronous active-low reset
//   arm_i          : pulse, clear state and start pre-trigger capture
//   trigger_i      : pulse, trigger event (honoured only in PRE)
//   post_words_i   : words to capture after trigger, sampled on arm
//   cap_valid_i    : cap_data_i valid this cycle
//   cap_data_i     : capture word
//   wr_if          : arbiter write port (wr_en/wr_addr/wr_data out, wr_ack in)
//   armed_o        : in PRE or POST
//   triggered_o    : sticky, trigger accepted since arm
//   done_o         : capture complete, every word written
//   overflow_o     : sticky, a word was dropped on a full FIFO
//   wrapped_o      : sticky, write index wrapped past RING_WORDS-1
//   trig_addr_o    : address of the first post-trigger word
// -----------------------------------------------------------------------------
module la_capture_writer #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [28:0] BASE_ADDR  = 29'h0,
    parameter int          RING_WORDS = 65536,
    parameter int          ADDR_STEP  = 4
) (
    input  logic                 clk_ram_2x,
    input  logic                 rst_n,
    input  logic                 arm_i,
    input  logic                 trigger_i,
    input  logic [31:0]          post_words_i,
    input  logic                 cap_valid_i,
    input  logic [127:0]         cap_data_i,
    la_capture_writer_if.master  wr_if,
    output logic                 armed_o,
    output logic                 triggered_o,
    output logic                 done_o,
    output logic                 overflow_o,
    output logic                 wrapped_o,
    output logic [28:0]          trig_addr_o
);

    localparam int IDX_W = (RING_WORDS > 1) ? $clog2(RING_WORDS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_POST  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [127:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [IDX_W-1:0]     in_idx_q, in_idx_d;
    logic [IDX_W-1:0]     out_idx_q, out_idx_d;
    logic [31:0]          post_cnt_q, post_cnt_d;
    logic [31:0]          post_words_q, post_words_d;
    logic                 armed_q, armed_d;
    logic                 triggered_q, triggered_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic                 wrapped_q, wrapped_d;
    logic [28:0]          trig_addr_q, trig_addr_d;

    logic                 fifo_empty_s;
    logic                 fifo_full_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 cap_open_s;

    // Ring index to DRAM address; product and sum truncate to 29 bits.
    function automatic logic [28:0] idx_to_addr(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + (29'(idx) * 29'(ADDR_STEP));
    endfunction

    assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
    assign fifo_full_s  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_s        = !fifo_empty_s && wr_if.wr_ack;

    // Write side: head of the FIFO is presented directly (fall-through); data is
    // forced to zero while nothing is offered so an idle port reads as zero.
    assign wr_if.wr_en   = !fifo_empty_s;
    assign wr_if.wr_addr = idx_to_addr(out_idx_q);
    assign wr_if.wr_data = fifo_empty_s ? 128'd0 : mem_q[rd_ptr_q];

    assign armed_o     = armed_q;
    assign triggered_o = triggered_q;
    assign done_o      = done_q;
    assign overflow_o  = overflow_q;
    assign wrapped_o   = wrapped_q;
    assign trig_addr_o = trig_addr_q;

    // Next-state logic: capture FSM, FIFO bookkeeping, ring indices and flags.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        in_idx_d     = in_idx_q;
        out_idx_d    = out_idx_q;
        post_cnt_d   = post_cnt_q;
        post_words_d = post_words_q;
        triggered_d  = triggered_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        wrapped_d    = wrapped_q;
        trig_addr_d  = trig_addr_q;
        cap_open_s   = 1'b0;
        push_s       = 1'b0;

        if (arm_i) begin
            // Arm wins over everything: FIFO flushed (wr_en drops next cycle even
            // mid-handshake), trigger and capture word of this cycle ignored.
            state_d      = ST_PRE;
            wr_ptr_d     = {PTR_W{1'b0}};
            rd_ptr_d     = {PTR_W{1'b0}};
            count_d      = {CNT_W{1'b0}};
            in_idx_d     = {IDX_W{1'b0}};
            out_idx_d    = {IDX_W{1'b0}};
            post_cnt_d   = 32'd0;
            post_words_d = post_words_i;
            triggered_d  = 1'b0;
            done_d       = 1'b0;
            overflow_d   = 1'b0;
            wrapped_d    = 1'b0;
        end else begin
            // A trigger with zero post words closes the input in the trigger cycle.
            case (state_q)
                ST_PRE:  cap_open_s = !(trigger_i && (post_words_q == 32'd0));
                ST_POST: cap_open_s = 1'b1;
                default: cap_open_s = 1'b0;
            endcase

            // Fullness is judged on the registered count: a same-cycle pop does
            // not make room for a push.
            push_s = cap_open_s && cap_valid_i && !fifo_full_s;

            if (cap_open_s && cap_valid_i && fifo_full_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end

            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
                in_idx_d = in_idx_q + IDX_W'(1'b1);
                if (in_idx_q == IDX_W'(RING_WORDS - 1)) begin
                    wrapped_d = 1'b1;
                end else begin
                    wrapped_d = wrapped_q;
                end
            end else begin
                wr_ptr_d = wr_ptr_q;
                in_idx_d = in_idx_q;
            end

            if (pop_s) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1'b1);
                out_idx_d = out_idx_q + IDX_W'(1'b1);
            end else begin
                rd_ptr_d  = rd_ptr_q;
                out_idx_d = out_idx_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase

            case (state_q)
                ST_PRE: begin
                    if (trigger_i) begin
                        triggered_d = 1'b1;
                        trig_addr_d = idx_to_addr(in_idx_q);
                        if (post_words_q == 32'd0) begin
                            post_cnt_d = 32'd0;
                            state_d    = ST_FLUSH;
                        end else if (push_s) begin
                            // The trigger-cycle word is the first post word.
                            post_cnt_d = post_words_q - 32'd1;
                            state_d    = (post_words_q == 32'd1) ? ST_FLUSH : ST_POST;
                        end else begin
                            post_cnt_d = post_words_q;
                            state_d    = ST_POST;
                        end
                    end else begin
                        state_d = ST_PRE;
                    end
                end
                ST_POST: begin
                    if (push_s) begin
                        post_cnt_d = post_cnt_q - 32'd1;
                        state_d    = (post_cnt_q == 32'd1) ? ST_FLUSH : ST_POST;
                    end else begin
                        state_d = ST_POST;
                    end
                end
                ST_FLUSH: begin
                    // Finish in the cycle of the last transfer so done rises
                    // right after it.
                    if (fifo_empty_s || ((count_q == CNT_W'(1'b1)) && pop_s)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
                ST_IDLE:  state_d = ST_IDLE;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end

        armed_d = (state_d == ST_PRE) || (state_d == ST_POST);
    end

    // Capture FIFO storage; contents need no reset since empty slots are never read out.
    always_ff @(posedge clk_ram_2x) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= cap_data_i;
        end
    end

    // State, index and flag registers.
    always_ff @(posedge clk_ram_2x or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            in_idx_q     <= {IDX_W{1'b0}};
            out_idx_q    <= {IDX_W{1'b0}};
            post_cnt_q   <= 32'd0;
            post_words_q <= 32'd0;
            armed_q      <= 1'b0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            wrapped_q    <= 1'b0;
            trig_addr_q  <= 29'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_idx_q     <= in_idx_d;
            out_idx_q    <= out_idx_d;
            post_cnt_q   <= post_cnt_d;
            post_words_q <= post_words_d;
            armed_q      <= armed_d;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            wrapped_q    <= wrapped_d;
            trig_addr_q  <= trig_addr_d;
        end
    end

endmodule

// File: tb/tb_la_capture_writer.sv
// -----------------------------------------------------------------------------
// tb_la_capture_writer
// Self-checking bench: a default instance checked every cycle against a
// queue-based reference model, plus a small-ring instance (RING_WORDS=8,
// BASE_ADDR=0x40) for wrap-around checks. Directed table, hand-written corner
// sequences and a randomized phase.
// -----------------------------------------------------------------------------
module tb_la_capture_writer;

    localparam int          DEPTH  = 16;
    localparam int          RING   = 65536;
    localparam int          STEP   = 4;
    localparam int          BASE   = 0;
    localparam logic [28:0] W_BASE = 29'h40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         arm = 1'b0, trig = 1'b0, cv = 1'b0, ack = 1'b0;
    logic [31:0]  pw = 32'd0;
    logic [127:0] cd = 128'd0;

    logic armed, triggered, done, overflow, wrapped;
    logic [28:0] trig_addr;
    logic armed_w, triggered_w, done_w, overflow_w, wrapped_w;
    logic [28:0] trig_addr_w;

    la_capture_writer_if wif ();
    la_capture_writer_if wif_w ();
    assign wif.wr_ack   = ack;
    assign wif_w.wr_ack = ack;

    always #5 clk = ~clk;

    la_capture_writer dut (
        .clk_ram_2x(clk), .rst_n(rst_n), .arm_i(arm), .trigger_i(trig),
        .post_words_i(pw), .cap_valid_i(cv), .cap_data_i(cd), .wr_if(wif),
        .armed_o(armed), .triggered_o(triggered), .done_o(done),
        .overflow_o(overflow), .wrapped_o(wrapped), .trig_addr_o(trig_addr));

    la_capture_writer #(.FIFO_DEPTH(16), .BASE_ADDR(W_BASE), .RING_WORDS(8), .ADDR_STEP(4)) dut_w (
        .clk_ram_2x(clk), .rst_n(rst_n), .arm_i(arm), .trigger_i(trig),
        .post_words_i(pw), .cap_valid_i(cv), .cap_data_i(cd), .wr_if(wif_w),
        .armed_o(armed_w), .triggered_o(triggered_w), .done_o(done_w),
        .overflow_o(overflow_w), .wrapped_o(wrapped_w), .trig_addr_o(trig_addr_w));

    int n_checks = 0;
    int n_err    = 0;
    int xfer_cnt = 0;
    logic [28:0]  w_addrs [$];
    logic [127:0] w_datas [$];

    // Reference model: phase 0 idle, 1 pre, 2 post, 3 flush, 4 done.
    int           m_ph;
    logic [127:0] m_q [$];
    int unsigned  m_in, m_out, m_pcnt, m_pwl;
    bit           m_trig, m_ovf, m_wrap, m_done;
    logic [28:0]  m_taddr;

    function automatic logic [28:0] m_addr(int unsigned idx);
        return 29'(BASE + idx * STEP);
    endfunction

    function automatic logic [127:0] word(int k);
        return {32'hC0DE_0000, 32'(k), 32'hA5A5_0000 ^ 32'(k), 32'(k * 7)};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ph = 0; m_in = 0; m_out = 0; m_pcnt = 0; m_pwl = 0;
        m_trig = 0; m_ovf = 0; m_wrap = 0; m_done = 0; m_taddr = 29'd0;
    endtask

    // One clock edge of the behaviour, from the inputs presented at that edge.
    task automatic model_step();
        bit pop, full, open_c, pushed;
        int unsigned old_in;
        if (!rst_n) begin model_reset(); return; end
        pop  = (m_q.size() > 0) && ack;
        full = (m_q.size() == DEPTH);
        if (arm) begin
            m_q.delete(); m_in = 0; m_out = 0; m_pcnt = 0;
            m_trig = 0; m_ovf = 0; m_wrap = 0; m_done = 0;
            m_pwl = pw; m_ph = 1;
            return;
        end
        if (pop) begin
            void'(m_q.pop_front());
            m_out = (m_out + 1) % RING;
        end
        old_in = m_in;
        open_c = (m_ph == 2) || (m_ph == 1 && !(trig && m_pwl == 0));
        pushed = 0;
        if (open_c && cv) begin
            if (full) m_ovf = 1;
            else begin
                m_q.push_back(cd);
                pushed = 1;
                if (m_in == RING - 1) m_wrap = 1;
                m_in = (m_in + 1) % RING;
            end
        end
        if (m_ph == 1 && trig) begin
            m_trig  = 1;
            m_taddr = m_addr(old_in);
            if (m_pwl == 0) m_ph = 3;
            else begin
                m_pcnt = m_pwl - (pushed ? 1 : 0);
                m_ph   = (m_pcnt == 0) ? 3 : 2;
            end
        end else if (m_ph == 2 && pushed) begin
            m_pcnt = m_pcnt - 1;
            if (m_pcnt == 0) m_ph = 3;
        end else if (m_ph == 3 && m_q.size() == 0) begin
            m_ph = 4; m_done = 1;
        end
    endtask

    task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic         e_en;
        logic [127:0] e_data;
        e_en   = (m_q.size() > 0);
        e_data = 128'd0;
        if (e_en) e_data = m_q[0];
        n_checks++;
        if (wif.wr_en !== e_en || wif.wr_addr !== m_addr(m_out) || wif.wr_data !== e_data ||
            armed !== (m_ph == 1 || m_ph == 2) || triggered !== m_trig || done !== m_done ||
            overflow !== m_ovf || wrapped !== m_wrap || trig_addr !== m_taddr) begin
            n_err++;
            $display("FAIL model_cycle t=%0t actual en=%b addr=%h data=%h arm=%b trg=%b dn=%b ovf=%b wrp=%b ta=%h required en=%b addr=%h data=%h arm=%b trg=%b dn=%b ovf=%b wrp=%b ta=%h",
                     $time, wif.wr_en, wif.wr_addr, wif.wr_data, armed, triggered, done, overflow, wrapped, trig_addr,
                     e_en, m_addr(m_out), e_data, (m_ph == 1 || m_ph == 2), m_trig, m_done, m_ovf, m_wrap, m_taddr);
        end
    endtask

    // Drive one cycle of inputs (at negedge), clock it, then compare at negedge.
    task automatic step(input bit a, input bit t, input logic [31:0] p, input bit v,
                        input logic [127:0] d, input bit k);
        arm = a; trig = t; pw = p; cv = v; cd = d; ack = k;
        #1;
        if (wif.wr_en && k) xfer_cnt++;
        if (wif_w.wr_en && k) begin
            w_addrs.push_back(wif_w.wr_addr);
            w_datas.push_back(wif_w.wr_data);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        bit a, t; logic [31:0] p; bit v, k;
        bit e_en; logic [28:0] e_addr; bit e_armed, e_trig, e_done;
    } vec_t;
    vec_t tbl [6];

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {wif.wr_en, wif.wr_addr, wif.wr_data, armed, triggered, done, overflow, wrapped, trig_addr},
            {1'b0, 29'd0, 128'd0, 5'b00000, 29'd0});
        rst_n = 1'b1;

        // Table: post_words=2, ack high; expectations after each edge.
        tbl[0] = '{1'b1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 29'd0,  1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 29'd0,  1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'd0, 1'b1, 1'b1, 1'b1, 29'd4,  1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 29'd8,  1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 29'd12, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 29'd12, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].a, tbl[i].t, tbl[i].p, tbl[i].v, word(100 + i), tbl[i].k);
            chk($sformatf("table_row%0d", i),
                {wif.wr_en, wif.wr_addr, armed, triggered, done},
                {tbl[i].e_en, tbl[i].e_addr, tbl[i].e_armed, tbl[i].e_trig, tbl[i].e_done});
        end
        chk("table_trig_addr", trig_addr, 29'd4);

        // Basic: 4 pre words, trigger word, 7 more; 12 writes, trig_addr 16.
        step(1, 0, 32'd8, 0, 128'd0, 1);
        xfer_cnt = 0;
        for (int i = 0; i < 4; i++) step(0, 0, 32'd0, 1, word(i), 1);
        step(0, 1, 32'd0, 1, word(4), 1);
        for (int i = 5; i < 12; i++) step(0, 0, 32'd0, 1, word(i), 1);
        for (int i = 0; i < 40 && !done; i++) step(0, 0, 32'd0, 0, 128'd0, 1);
        chk("basic_xfers", xfer_cnt, 12);
        chk("basic_flags", {done, overflow, trig_addr}, {1'b1, 1'b0, 29'd16});

        // Backpressure: 20 words into a 16-deep FIFO with ack low.
        step(1, 0, 32'd100, 0, 128'd0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 32'd0, 1, word(200 + i), 0);
            chk("stall_hold", {wif.wr_en, wif.wr_addr, wif.wr_data}, {1'b1, 29'd0, word(200)});
        end
        chk("stall_overflow", overflow, 1'b1);
        xfer_cnt = 0;
        for (int i = 0; i < 20; i++) step(0, 0, 32'd0, 0, 128'd0, 1);
        chk("stall_drain", {xfer_cnt, 31'd0, wif.wr_en}, {32'd16, 31'd0, 1'b0});

        // Wrap on the 8-word ring: 10 pre words, trigger, post_words=2.
        step(1, 0, 32'd2, 0, 128'd0, 1);
        w_addrs.delete(); w_datas.delete();
        for (int i = 0; i < 10; i++) step(0, 0, 32'd0, 1, word(300 + i), 1);
        step(0, 1, 32'd0, 1, word(310), 1);
        step(0, 0, 32'd0, 1, word(311), 1);
        for (int i = 0; i < 20 && !done_w; i++) step(0, 0, 32'd0, 0, 128'd0, 1);
        chk("wrap_count", w_addrs.size(), 12);
        chk("wrap_addr8", (w_addrs.size() > 8) ? w_addrs[8] : 29'h1FFF_FFFF, W_BASE);
        chk("wrap_data8", (w_datas.size() > 8) ? w_datas[8] : 128'd0, word(308));
        chk("wrap_addr9", (w_addrs.size() > 9) ? w_addrs[9] : 29'h1FFF_FFFF, W_BASE + 29'd4);
        chk("wrap_flags", {wrapped_w, done_w, trig_addr_w}, {1'b1, 1'b1, W_BASE + 29'd8});

        // post_words=0: trigger word rejected, FLUSH for one cycle, then DONE.
        step(1, 0, 32'd0, 0, 128'd0, 1);
        xfer_cnt = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 32'd0, 1, word(400 + i), 1);
        step(0, 1, 32'd0, 1, word(403), 1);
        chk("post0_flush", {armed, triggered, done, trig_addr}, {3'b010, 29'd12});
        step(0, 0, 32'd0, 1, word(404), 1);
        chk("post0_done", done, 1'b1);
        step(0, 0, 32'd0, 0, 128'd0, 1);
        chk("post0_xfers", xfer_cnt, 3);

        // Re-arm mid-POST with 3 words held.
        step(1, 0, 32'd10, 0, 128'd0, 0);
        step(0, 0, 32'd0, 1, word(500), 0);
        step(0, 0, 32'd0, 1, word(501), 0);
        step(0, 1, 32'd0, 1, word(502), 0);
        chk("rearm_pre", {wif.wr_en, triggered}, {1'b1, 1'b1});
        step(1, 0, 32'd4, 1, word(503), 0);
        chk("rearm_clear", {wif.wr_en, triggered, armed, wif.wr_addr}, {1'b0, 1'b0, 1'b1, 29'd0});
        step(0, 0, 32'd0, 1, word(510), 0);
        chk("rearm_first", {wif.wr_en, wif.wr_addr, wif.wr_data}, {1'b1, 29'd0, word(510)});

        // Async reset mid-transfer.
        for (int i = 0; i < 3; i++) step(0, 0, 32'd0, 1, word(520 + i), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset",
            {wif.wr_en, wif.wr_addr, wif.wr_data, armed, triggered, done, overflow, wrapped, trig_addr},
            {1'b0, 29'd0, 128'd0, 5'b00000, 29'd0});
        chk("async_reset_w", {wif_w.wr_en, wif_w.wr_addr, armed_w, triggered_w},
            {1'b0, W_BASE, 2'b00});
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        xfer_cnt = 0;
        for (int i = 0; i < 5; i++) step(0, 1, 32'd0, 1, word(530 + i), 1);
        chk("post_reset_idle", {xfer_cnt, 31'd0, wif.wr_en}, {32'd0, 31'd0, 1'b0});

        // Randomized phase against the model.
        step(1, 0, 32'd3, 0, 128'd0, 0);
        begin
            int bias;
            bias = 50;
            for (int i = 0; i < 3000; i++) begin
                bit a;
                if (i % 256 == 0) bias = $urandom_range(10, 95);
                a = ($urandom % 200 == 0) || (done && ($urandom % 4 == 0));
                step(a, ($urandom % 25 == 0), 32'($urandom_range(0, 6)), ($urandom % 4 != 0),
                     {$urandom, $urandom, $urandom, $urandom}, (int'($urandom % 100) < bias));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/la_capture_writer.md
# la_capture_writer

Capture-side write client for one logic-analyzer channel, running in the clk_ram_2x domain and feeding one 128-bit client port (laN_wr_*) of the memory arbiter. Accepts a stream of 128-bit capture words, buffers them in a small FIFO, and writes them into a circular DRAM region. Supports arm, trigger, and a post-trigger word count, then flushes and reports the trigger address for readout. One instance per channel (la0, la1).

## Interface
- FIFO_DEPTH, 16: capture FIFO depth in 128-bit words; power of 2, ≥4
- BASE_ADDR, 29'h0: DRAM address of ring word 0
- RING_WORDS, 65536: ring size in 128-bit words; power of 2
- ADDR_STEP, 4: app_addr increment per 128-bit word
- clk_ram_2x  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- arm  in  1  pulse: clear state, start pre-trigger capture
- trigger  in  1  pulse: trigger event
- post_words  in  32  words to capture after trigger, sampled on arm
- cap_valid  in  1  cap_data valid this cycle
- cap_data  in  128  capture word
- wr_en  out  1  write request to arbiter
- wr_addr  out  29  DRAM address of wr_data
- wr_data  out  128  write data
- wr_ack  in  1  arbiter accepts the current word
- armed  out  1  in PRE or POST
- triggered  out  1  sticky; trigger accepted since arm
- done  out  1  capture complete, all words written
- overflow  out  1  sticky; a word was dropped due to a full FIFO
- wrapped  out  1  sticky; in_idx has wrapped past RING_WORDS-1
- trig_addr  out  29  address of first post-trigger word

## Operation
- States: IDLE, PRE, POST, FLUSH, DONE.
- IDLE: no words accepted. Arm → PRE.
- On arm (any state): flush the FIFO, clear in_idx, out_idx, post_cnt, triggered, overflow, wrapped, done; latch post_words; drop wr_en the next cycle, even mid-handshake. The arbiter tolerates an abandoned request.
- PRE/POST: if cap_valid and the FIFO is not full, push cap_data and increment in_idx modulo RING_WORDS. Set wrapped when in_idx goes from RING_WORDS-1 to 0.
- If cap_valid while the FIFO is full, drop the word and set overflow. in_idx is not incremented.
- PRE + trigger:
  - set triggered;
  - trig_addr = BASE_ADDR + in_idx*ADDR_STEP, using in_idx before that cycle's push;
  - post_cnt = latched post_words.
  - If post_words ≥ 1: go to POST. A trigger-cycle word, if pushed, counts as the first post word.
  - If post_words = 0: go to FLUSH, and do not accept the trigger-cycle word.
- POST: each pushed word decrements post_cnt. The push that takes it to 0 → FLUSH. Triggers in POST are ignored. A trigger in the same cycle as arm is ignored.
- FLUSH: accept no input; drain the FIFO. When the FIFO is empty and no transfer is pending → DONE.
- DONE: done=1 until the next arm. In IDLE/DONE the FIFO is empty and wr_en=0.
- Write side:
  - wr_en = FIFO not empty.
  - wr_data = FIFO head (first-word-fall-through).
  - wr_addr = BASE_ADDR + out_idx*ADDR_STEP.
  - A transfer occurs on a cycle with wr_en && wr_ack. It pops the head and increments out_idx modulo RING_WORDS.
  - wr_addr/wr_data stay stable while wr_en=1 and wr_ack=0.
- Arithmetic: in_idx/out_idx are log2(RING_WORDS) bits and wrap naturally. The address product and sum are 29-bit, truncating. post_cnt is 32-bit.
- Simultaneous push and pop on a full FIFO: the pop frees a slot only the next cycle. A push when full is dropped even if a pop occurs in the same cycle.

## Timing
- Reset values: wr_en=0, wr_addr=BASE_ADDR, wr_data=0, armed=0, triggered=0, done=0, overflow=0, wrapped=0, trig_addr=0; state IDLE.
- Capture to write latency: a word pushed at cycle N is presented with wr_en=1 at cycle N+1 if the FIFO was empty.
- Throughput: 1 word/cycle sustained when wr_ack is held high.
- armed/triggered/done/overflow/wrapped are registered and update the cycle after the causing event.
- done rises the cycle after the last transfer.

## Test plan
- Basic: arm with post_words=8; 4 pre words; trigger with cap_valid; 7 more words; wr_ack=1.
  - Expect 12 transfers at addresses 0,4,…,44.
  - Expect trig_addr=16, done=1, overflow=0.
- Backpressure: hold wr_ack=0 for 20 cycles while 20 words arrive at FIFO_DEPTH=16.
  - Expect the first 16 held and overflow=1.
  - Expect wr_addr/wr_data stable during the stall; after ack, 16 writes in order.
- Wrap: RING_WORDS=8, 10 pre words, then trigger with post_words=2.
  - Expect wrapped=1 and writes 8 and 9 at addresses 0 and 4.
  - Expect trig_addr=BASE_ADDR+(10 mod 8)*4=8.
- post_words=0: trigger while cap_valid=1.
  - Expect the trigger word not written, state FLUSH then DONE, trig_addr = address of the next unused index.
- Re-arm mid-POST with 3 words in the FIFO and wr_ack=0.
  - Expect wr_en=0 the next cycle and counters cleared.
  - Expect the next capture to start at BASE_ADDR.
- Async reset asserted mid-transfer: all outputs return to reset values immediately; no transfer after rst_n deasserts until arm.
